// File: rtl/multicycle_core.sv
// multicycle_core: multicycle MIPS-subset core (lw, sw, add, sub, and, or,
// slt, beq, addi, j). One shared ALU and one unified memory port with a
// ready handshake. Each instruction steps through several FSM states.
module multicycle_core #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             memreq,
  output logic             memwe,
  output logic [WIDTH-1:0] memaddr,
  output logic [WIDTH-1:0] memwdata,
  input  logic [WIDTH-1:0] memrdata,
  input  logic             memready,
  output logic [WIDTH-1:0] pc,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_ZERO
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t           st;
  logic [31:0]      ir;
  logic [WIDTH-1:0] a, b, aluout, mdr;
  logic [WIDTH-1:0] rf [32];

  logic [5:0]       op, funct;
  logic [4:0]       rs, rt, rd;
  logic [WIDTH-1:0] signimm;
  logic [WIDTH-1:0] rf_rs, rf_rt;

  logic [WIDTH-1:0] alu_x, alu_y, alu_res;
  aluop_t           alu_op;

  logic             rf_we;
  logic [4:0]       rf_wa;
  logic [WIDTH-1:0] rf_wd;

  assign op      = ir[31:26];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign funct   = ir[5:0];
  assign signimm = {{(WIDTH-16){ir[15]}}, ir[15:0]};
  assign rf_rs   = (rs == 5'd0) ? '0 : rf[rs];
  assign rf_rt   = (rt == 5'd0) ? '0 : rf[rt];
  assign state   = st;

  // Shared ALU operand and operation select, driven by the current state
  always_comb begin
    alu_x  = pc;
    alu_y  = {{(WIDTH-3){1'b0}}, 3'd4};
    alu_op = ALU_ADD;
    case (st)
      DECODE: alu_y = signimm << 2;
      MEMADR, ADDIEX: begin
        alu_x = a;
        alu_y = signimm;
      end
      EXECUTE: begin
        alu_x = a;
        alu_y = b;
        case (funct)
          6'h20:   alu_op = ALU_ADD;
          6'h22:   alu_op = ALU_SUB;
          6'h24:   alu_op = ALU_AND;
          6'h25:   alu_op = ALU_OR;
          6'h2A:   alu_op = ALU_SLT;
          default: alu_op = ALU_ZERO;
        endcase
      end
      default: ;
    endcase
  end

  // ALU datapath; arithmetic wraps, slt is a signed compare
  always_comb begin
    case (alu_op)
      ALU_ADD: alu_res = alu_x + alu_y;
      ALU_SUB: alu_res = alu_x - alu_y;
      ALU_AND: alu_res = alu_x & alu_y;
      ALU_OR:  alu_res = alu_x | alu_y;
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(alu_x) < $signed(alu_y))};
      default: alu_res = '0;
    endcase
  end

  // Register-file write port selection for the three write-back states
  always_comb begin
    rf_we = 1'b0;
    rf_wa = rt;
    rf_wd = aluout;
    case (st)
      MEMWB: begin
        rf_we = 1'b1;
        rf_wd = mdr;
      end
      ALUWB: begin
        rf_we = 1'b1;
        rf_wa = rd;
      end
      ADDIWB: rf_we = 1'b1;
      default: ;
    endcase
  end

  // Register file: not cleared by reset, writes to $0 dropped
  always_ff @(posedge clk) begin
    if (!reset && rf_we && (rf_wa != 5'd0)) begin
      rf[rf_wa] <= rf_wd;
    end
  end

  // Controller FSM plus PC, IR and internal datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      st     <= FETCH;
      pc     <= RESET_PC;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
      mdr    <= '0;
    end else begin
      case (st)
        FETCH: begin
          if (memready) begin
            ir <= memrdata[31:0];
            pc <= alu_res;
            st <= DECODE;
          end
        end
        DECODE: begin
          a      <= rf_rs;
          b      <= rf_rt;
          aluout <= alu_res;
          case (op)
            OP_LW, OP_SW: st <= MEMADR;
            OP_RTYPE:     st <= EXECUTE;
            OP_BEQ:       st <= BRANCH;
            OP_ADDI:      st <= ADDIEX;
            OP_J:         st <= JUMP;
            default:      st <= FETCH;
          endcase
        end
        MEMADR: begin
          aluout <= alu_res;
          st     <= (op == OP_LW) ? MEMRD : MEMWR;
        end
        MEMRD: begin
          if (memready) begin
            mdr <= memrdata;
            st  <= MEMWB;
          end
        end
        MEMWB: st <= FETCH;
        MEMWR: begin
          if (memready) st <= FETCH;
        end
        EXECUTE: begin
          aluout <= alu_res;
          st     <= ALUWB;
        end
        ALUWB: st <= FETCH;
        BRANCH: begin
          if (a == b) pc <= aluout;
          st <= FETCH;
        end
        ADDIEX: begin
          aluout <= alu_res;
          st     <= ADDIWB;
        end
        ADDIWB: st <= FETCH;
        JUMP: begin
          pc <= {pc[WIDTH-1:28], ir[25:0], 2'b00};
          st <= FETCH;
        end
        default: st <= FETCH;
      endcase
    end
  end

  // Memory port decoded from the registered state; forced idle during
  // reset so an in-flight access is dropped in the reset cycle itself
  always_comb begin
    memreq   = 1'b0;
    memwe    = 1'b0;
    memaddr  = '0;
    memwdata = '0;
    if (!reset) begin
      case (st)
        FETCH: begin
          memreq  = 1'b1;
          memaddr = pc;
        end
        MEMRD: begin
          memreq  = 1'b1;
          memaddr = aluout;
        end
        MEMWR: begin
          memreq   = 1'b1;
          memwe    = 1'b1;
          memaddr  = aluout;
          memwdata = b;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: directed and random programs run on multicycle_core.
// An ISA-level model predicts every memory access (cycle, address, kind,
// store data); a memory responder with configurable wait states logs them.
module tb_multicycle_core;

  localparam logic [31:0] RST = 32'h100;

  logic        clk;
  logic        reset;
  logic        memreq, memwe, memready;
  logic [31:0] memaddr, memwdata, memrdata, pc;
  logic [3:0]  state;

  multicycle_core #(.WIDTH(32), .RESET_PC(RST)) dut (
    .clk      (clk),
    .reset    (reset),
    .memreq   (memreq),
    .memwe    (memwe),
    .memaddr  (memaddr),
    .memwdata (memwdata),
    .memrdata (memrdata),
    .memready (memready),
    .pc       (pc),
    .state    (state)
  );

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } acc_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          waits   = 0;
  acc_t        log_q[$];
  acc_t        exp_q[$];
  acc_t        cur;
  logic [31:0] mem  [512];
  logic [31:0] mmem [512];
  logic [31:0] mregs[32];
  logic [31:0] prog[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
    end
  endtask

  // Memory responder: logs each access start, checks stability while waiting
  initial begin
    int  wcnt;
    bit  busy;
    wcnt     = 0;
    busy     = 1'b0;
    memready = 1'b0;
    memrdata = '0;
    forever begin
      @(negedge clk);
      if (memreq === 1'b1) begin
        if (!busy) begin
          busy = 1'b1;
          wcnt = 0;
          cur.cyc  = cyc;
          cur.addr = memaddr;
          cur.we   = memwe;
          cur.data = memwdata;
          log_q.push_back(cur);
        end else begin
          check("stable_addr", memaddr, cur.addr);
          check("stable_we", {31'b0, memwe}, {31'b0, cur.we});
          if (cur.we) check("stable_wdata", memwdata, cur.data);
        end
        if (wcnt >= waits) begin
          memready = 1'b1;
          if (memwe) mem[memaddr[10:2]] = memwdata;
          else       memrdata = mem[memaddr[10:2]];
          busy = 1'b0;
        end else begin
          memready = 1'b0;
          memrdata = $urandom;
          wcnt++;
        end
      end else begin
        memready = 1'b0;
        memrdata = $urandom;
        busy     = 1'b0;
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] target);
    return {6'h02, target[27:2]};
  endfunction

  task automatic poke(input logic [31:0] addr, input logic [31:0] v);
    mem[addr[10:2]]  = v;
    mmem[addr[10:2]] = v;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 512; i++) begin
      mem[i]  = '0;
      mmem[i] = '0;
    end
    foreach (prog[i]) poke(RST + 32'(4 * i), prog[i]);
  endtask

  task automatic push_exp(input int c, input logic [31:0] ad, input logic we, input logic [31:0] d);
    acc_t e;
    e.cyc  = c;
    e.addr = ad;
    e.we   = we;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // ISA-level model: executes n instructions, predicting every access and its start cycle
  task automatic model_run(input int n, input int w, input int t0);
    logic [31:0] mpc, ins, ra, rb, simm, ea, npc, res;
    int          t, cost;
    mpc = RST;
    t   = t0;
    repeat (n) begin
      ins = mmem[mpc[10:2]];
      push_exp(t, mpc, 1'b0, 32'h0);
      ra   = mregs[ins[25:21]];
      rb   = mregs[ins[20:16]];
      simm = {{16{ins[15]}}, ins[15:0]};
      npc  = mpc + 32'd4;
      cost = 2 + w;
      case (ins[31:26])
        6'h23: begin
          ea = ra + simm;
          push_exp(t + w + 3, ea, 1'b0, 32'h0);
          if (ins[20:16] != 5'd0) mregs[ins[20:16]] = mmem[ea[10:2]];
          cost = 5 + 2 * w;
        end
        6'h2B: begin
          ea = ra + simm;
          push_exp(t + w + 3, ea, 1'b1, rb);
          mmem[ea[10:2]] = rb;
          cost = 4 + 2 * w;
        end
        6'h00: begin
          case (ins[5:0])
            6'h20:   res = ra + rb;
            6'h22:   res = ra - rb;
            6'h24:   res = ra & rb;
            6'h25:   res = ra | rb;
            6'h2A:   res = ($signed(ra) < $signed(rb)) ? 32'd1 : 32'd0;
            default: res = 32'd0;
          endcase
          if (ins[15:11] != 5'd0) mregs[ins[15:11]] = res;
          cost = 4 + w;
        end
        6'h04: begin
          if (ra == rb) npc = npc + (simm << 2);
          cost = 3 + w;
        end
        6'h08: begin
          if (ins[20:16] != 5'd0) mregs[ins[20:16]] = ra + simm;
          cost = 4 + w;
        end
        6'h02: begin
          npc  = {npc[31:28], ins[25:0], 2'b00};
          cost = 3 + w;
        end
        default: ;
      endcase
      mpc = npc;
      t   = t + cost;
    end
  endtask

  task automatic hold_reset();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Reset, release, and compare observed accesses with the model's prediction
  task automatic run_prog(input string name, input int n, input int w);
    int start, guard;
    waits = w;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check({name, "_rst_memreq"}, {31'b0, memreq}, 32'd0);
    check({name, "_rst_memwe"}, {31'b0, memwe}, 32'd0);
    check({name, "_rst_memaddr"}, memaddr, 32'd0);
    check({name, "_rst_memwdata"}, memwdata, 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    log_q.delete();
    exp_q.delete();
    reset = 1'b0;
    start = cyc;
    model_run(n, w, start);
    @(negedge clk);
    check({name, "_first_memreq"}, {31'b0, memreq}, 32'd1);
    check({name, "_first_memaddr"}, memaddr, RST);
    if (w == 0) begin
      @(negedge clk);
      check({name, "_pc_after_fetch"}, pc, RST + 32'd4);
    end
    guard = 0;
    while (log_q.size() < exp_q.size() && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (log_q.size() < exp_q.size())
      check({name, "_timeout_accesses"}, 32'(log_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < log_q.size()) begin
        check($sformatf("%s_acc%0d_cyc", name, i), 32'(log_q[i].cyc), 32'(exp_q[i].cyc));
        check($sformatf("%s_acc%0d_addr", name, i), log_q[i].addr, exp_q[i].addr);
        check($sformatf("%s_acc%0d_we", name, i), {31'b0, log_q[i].we}, {31'b0, exp_q[i].we});
        if (exp_q[i].we)
          check($sformatf("%s_acc%0d_wdata", name, i), log_q[i].data, exp_q[i].data);
      end
    end
  endtask

  initial begin
    int          start, guard, kind;
    logic [4:0]  r1, r2, r3;
    logic [15:0] imm;
    logic [5:0]  fns[5];
    logic [5:0]  bad_ops[4];
    fns     = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    bad_ops = '{6'h01, 6'h03, 6'h0D, 6'h3F};
    reset = 1'b1;
    for (int i = 0; i < 32; i++) mregs[i] = 'x;
    mregs[0] = 32'd0;

    // Arithmetic, plus reset/first-fetch behaviour
    hold_reset();
    prog.delete();
    prog.push_back(enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    prog.push_back(enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));
    prog.push_back(enc_r(5'd1, 5'd2, 5'd3, 6'h20));
    prog.push_back(enc_r(5'd2, 5'd1, 5'd4, 6'h22));
    prog.push_back(enc_r(5'd2, 5'd1, 5'd5, 6'h2A));
    prog.push_back(enc_i(6'h2B, 5'd0, 5'd3, 16'h060C));
    prog.push_back(enc_i(6'h2B, 5'd0, 5'd4, 16'h0610));
    prog.push_back(enc_i(6'h2B, 5'd0, 5'd5, 16'h0614));
    prog.push_back(enc_j(RST + 32'd32));
    load_prog();
    run_prog("arith", 10, 0);
    if (log_q.size() >= 11) begin
      check("arith_5instr_cycles", 32'(log_q[5].cyc - log_q[0].cyc), 32'd20);
      check("arith_rf3", log_q[6].data, 32'd2);
      check("arith_rf4", log_q[8].data, 32'hFFFFFFF8);
      check("arith_rf5", log_q[10].data, 32'd1);
    end else check("arith_log_size", 32'(log_q.size()), 32'd11);

    // Store then load with 3 wait states per access
    hold_reset();
    prog.delete();
    prog.push_back(enc_i(6'h23, 5'd0, 5'd1, 16'h0500));
    prog.push_back(enc_i(6'h2B, 5'd0, 5'd1, 16'h0008));
    prog.push_back(enc_i(6'h23, 5'd0, 5'd6, 16'h0008));
    prog.push_back(enc_i(6'h2B, 5'd0, 5'd6, 16'h0618));
    prog.push_back(enc_j(RST + 32'd16));
    load_prog();
    poke(32'h500, 32'h0000DEAD);
    run_prog("memwait", 6, 3);
    if (log_q.size() >= 9) begin
      check("memwait_sw_addr", log_q[3].addr, 32'd8);
      check("memwait_sw_we", {31'b0, log_q[3].we}, 32'd1);
      check("memwait_sw_data", log_q[3].data, 32'h0000DEAD);
      check("memwait_sw_cycles", 32'(log_q[4].cyc - log_q[2].cyc), 32'd10);
      check("memwait_lw_cycles", 32'(log_q[6].cyc - log_q[4].cyc), 32'd11);
      check("memwait_rf6", log_q[7].data, 32'h0000DEAD);
    end else check("memwait_log_size", 32'(log_q.size()), 32'd9);

    // Taken beq, untaken beq, jump
    hold_reset();
    prog.delete();
    prog.push_back(enc_i(6'h04, 5'd0, 5'd0, 16'd2));
    prog.push_back(enc_i(6'h08, 5'd0, 5'd9, 16'd9));
    prog.push_back(enc_i(6'h08, 5'd0, 5'd9, 16'd9));
    prog.push_back(enc_i(6'h08, 5'd0, 5'd1, 16'd1));
    prog.push_back(enc_i(6'h04, 5'd1, 5'd0, 16'd5));
    prog.push_back(enc_j(32'h100));
    load_prog();
    run_prog("brj", 6, 0);
    if (log_q.size() >= 5) begin
      check("brj_taken_target", log_q[1].addr, 32'h10C);
      check("brj_beq_cycles", 32'(log_q[1].cyc - log_q[0].cyc), 32'd3);
      check("brj_untaken_target", log_q[3].addr, 32'h114);
      check("brj_jump_target", log_q[4].addr, 32'h100);
      check("brj_j_cycles", 32'(log_q[4].cyc - log_q[3].cyc), 32'd3);
    end else check("brj_log_size", 32'(log_q.size()), 32'd5);

    // Writes to $0 and an illegal opcode
    hold_reset();
    prog.delete();
    prog.push_back(enc_i(6'h08, 5'd0, 5'd0, 16'd7));
    prog.push_back(32'hFC000000);
    prog.push_back(enc_i(6'h2B, 5'd0, 5'd0, 16'h0600));
    prog.push_back(enc_j(RST + 32'd12));
    load_prog();
    run_prog("zero", 5, 0);
    if (log_q.size() >= 4) begin
      check("zero_nop_cycles", 32'(log_q[2].cyc - log_q[1].cyc), 32'd2);
      check("zero_nop_pc", log_q[2].addr, 32'h108);
      check("zero_rf0", log_q[3].data, 32'd0);
    end else check("zero_log_size", 32'(log_q.size()), 32'd4);

    // Random program: init all registers, random ops, dump every register
    hold_reset();
    prog.delete();
    for (int r = 1; r < 32; r++)
      prog.push_back(enc_i(6'h08, 5'd0, 5'(r), 16'($urandom)));
    for (int k = 0; k < 24; k++) begin
      kind = $urandom_range(0, 7);
      r1 = 5'($urandom);
      r2 = 5'($urandom);
      r3 = 5'($urandom);
      imm = 16'(32'h400 + 4 * $urandom_range(0, 15));
      case (kind)
        0, 7: prog.push_back(enc_r(r1, r2, r3, fns[$urandom_range(0, 4)]));
        1:    prog.push_back(enc_r(r1, r2, r3, 6'h3F));
        2:    prog.push_back(enc_i(6'h08, r1, r2, 16'($urandom)));
        3:    prog.push_back(enc_i(6'h2B, 5'd0, r2, imm));
        4:    prog.push_back(enc_i(6'h23, 5'd0, r2, imm));
        5:    prog.push_back(enc_i(6'h04, r1, ($urandom_range(0, 1) == 1) ? r1 : r2, 16'd1));
        default: prog.push_back({bad_ops[$urandom_range(0, 3)], 26'($urandom)});
      endcase
    end
    for (int r = 0; r < 32; r++)
      prog.push_back(enc_i(6'h2B, 5'd0, 5'(r), 16'(32'h600 + 4 * r)));
    prog.push_back(enc_j(RST + 32'(4 * prog.size())));
    load_prog();
    for (int k = 0; k < 16; k++) poke(32'h400 + 32'(4 * k), $urandom);
    run_prog("rand", 90, $urandom_range(0, 2));

    // Reset while a load is waiting for memready
    hold_reset();
    prog.delete();
    prog.push_back(enc_i(6'h23, 5'd0, 5'd7, 16'h0040));
    prog.push_back(enc_j(RST + 32'd4));
    load_prog();
    waits = 0;
    @(posedge clk);
    #1;
    log_q.delete();
    reset = 1'b0;
    start = cyc;
    guard = 0;
    while (log_q.size() < 1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 waits = 100;
    guard = 0;
    while (log_q.size() < 2 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (log_q.size() >= 2) begin
      check("midrst_rd_addr", log_q[1].addr, 32'h40);
      check("midrst_rd_cyc", 32'(log_q[1].cyc), 32'(start + 3));
    end else check("midrst_timeout", 32'(log_q.size()), 32'd2);
    @(negedge clk);
    check("midrst_waiting_memreq", {31'b0, memreq}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midrst_reset_memreq", {31'b0, memreq}, 32'd0);
    check("midrst_reset_memaddr", memaddr, 32'd0);
    waits = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_refetch_memreq", {31'b0, memreq}, 32'd1);
    check("midrst_refetch_memaddr", memaddr, RST);
    check("midrst_refetch_memwe", {31'b0, memwe}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
